// File: rtl/multdiv_issue_ctrl_pkg.sv
// Processor-wide constants shared by the mult/div issue controller.
// Holds the opcode fields, the exception rewrite values and the controller state encoding.
package multdiv_issue_ctrl_pkg;

    localparam logic [4:0]  OPC_RTYPE     = 5'd0;
    localparam logic [4:0]  ALU_MULT      = 5'd6;
    localparam logic [4:0]  ALU_DIV       = 5'd7;

    localparam logic [31:0] SETX_MULT_EXC = 32'hA800_0004;
    localparam logic [31:0] SETX_DIV_EXC  = 32'hA800_0005;
    localparam logic [31:0] STATUS_MULT   = 32'd4;
    localparam logic [31:0] STATUS_DIV    = 32'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } md_state_e;

    function automatic logic is_md_instr(input logic [31:0] instr);
        return (instr[31:27] == OPC_RTYPE) &&
               ((instr[6:2] == ALU_MULT) || (instr[6:2] == ALU_DIV));
    endfunction

endpackage

// File: rtl/multdiv_issue_ctrl_watchdog.sv
// Cycle counter that flags a mult/div unit which has run for MAX_CYCLES without reporting ready.
// Clear has priority over enable; the owner stops enabling it once the operation ends.
module md_watchdog #(
    parameter int MAX_CYCLES = 40,
    parameter int CNT_W      = 6
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == MAX_CNT);

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Execute-stage sequencer for the multicycle mult/div unit: start pulse, pipeline stall,
// operand latching, one-cycle result hand-off to X/M, exception rewrite and watchdog abort.
module multdiv_issue_ctrl
    import multdiv_issue_ctrl_pkg::*;
#(
    parameter int MAX_CYCLES = 40,
    parameter int CNT_W      = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instr_x,
    input  logic [31:0] a_x,
    input  logic [31:0] b_x,
    input  logic        flush,
    input  logic        md_ready,
    input  logic        md_exception,
    input  logic [31:0] md_result,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    output logic        ctrl_mult,
    output logic        ctrl_div,
    output logic        stall,
    output logic        res_valid,
    output logic [31:0] result,
    output logic [31:0] instr_out,
    output logic        timeout,
    output md_state_e   state_dbg
);

    // Handshake: ctrl_mult/ctrl_div are single-cycle starts with no back-pressure; md_ready
    // (with md_exception/md_result) is honoured only while BUSY; res_valid is a one-cycle
    // strobe that X/M must capture, since the stall has already dropped in that cycle.

    md_state_e   state_q, state_d;
    logic [31:0] md_a_q, md_a_d;
    logic [31:0] md_b_q, md_b_d;
    logic [31:0] instr_q, instr_d;
    logic        is_mult_q, is_mult_d;
    logic [31:0] result_q, result_d;
    logic [31:0] instr_out_q, instr_out_d;
    logic        timeout_q, timeout_d;

    logic        start;
    logic        start_mult;
    logic        wd_clear;
    logic        wd_enable;
    logic        wd_expired;

    md_watchdog #(
        .MAX_CYCLES (MAX_CYCLES),
        .CNT_W      (CNT_W)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    assign start_mult = (instr_x[6:2] == ALU_MULT);

    always_comb begin
        state_d     = state_q;
        md_a_d      = md_a_q;
        md_b_d      = md_b_q;
        instr_d     = instr_q;
        is_mult_d   = is_mult_q;
        result_d    = result_q;
        instr_out_d = instr_out_q;
        timeout_d   = timeout_q;
        start       = 1'b0;
        wd_clear    = 1'b0;
        wd_enable   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (is_md_instr(instr_x) && !flush) begin
                    start     = 1'b1;
                    wd_clear  = 1'b1;
                    md_a_d    = a_x;
                    md_b_d    = b_x;
                    instr_d   = instr_x;
                    is_mult_d = start_mult;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                wd_enable = 1'b1;
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (md_ready && !md_exception) begin
                    result_d    = md_result;
                    instr_out_d = instr_q;
                    state_d     = ST_DONE;
                end else if (md_ready || wd_expired) begin
                    // A hung unit is reported to software exactly like a unit exception.
                    result_d    = is_mult_q ? STATUS_MULT   : STATUS_DIV;
                    instr_out_d = is_mult_q ? SETX_MULT_EXC : SETX_DIV_EXC;
                    timeout_d   = timeout_q | (!md_ready && wd_expired);
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            md_a_q      <= '0;
            md_b_q      <= '0;
            instr_q     <= '0;
            is_mult_q   <= 1'b0;
            result_q    <= '0;
            instr_out_q <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            md_a_q      <= md_a_d;
            md_b_q      <= md_b_d;
            instr_q     <= instr_d;
            is_mult_q   <= is_mult_d;
            result_q    <= result_d;
            instr_out_q <= instr_out_d;
            timeout_q   <= timeout_d;
        end
    end

    assign ctrl_mult = start && start_mult;
    assign ctrl_div  = start && !start_mult;
    assign stall     = start || (state_q == ST_BUSY);
    assign res_valid = (state_q == ST_DONE);
    assign md_a      = md_a_q;
    assign md_b      = md_b_q;
    assign result    = result_q;
    assign instr_out = instr_out_q;
    assign timeout   = timeout_q;
    assign state_dbg = state_q;

endmodule
